// File: rtl/mux_pipe_n_pkg.sv
// Shared constants and helpers for the pipelined N-input selector.
package mux_pipe_n_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

  // A select port is never narrower than one bit, even for a single-input mux.
  function automatic int unsigned sel_width(input int unsigned n_in);
    return (clog2(n_in) < 1) ? 1 : clog2(n_in);
  endfunction

  // Forwarding select encodings used by the CPU datapath.
  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_EX   = 2'd1;
  localparam logic [1:0] FWD_MEM  = 2'd2;
  localparam logic [1:0] FWD_WB   = 2'd3;

endpackage

// File: rtl/mux_pipe_stage.sv
// One elastic valid/data register slice with a combinational ready chain and flush.
module mux_pipe_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             rdy_next_i,
  output logic             rdy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign rdy_o   = ~valid_q | rdy_next_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (valid_i && rdy_o) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (rdy_next_i) begin
      // Our beat (if any) moved downstream and nothing replaced it.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/mux_pipe_n.sv
// N-input selector feeding an elastic pipeline of register slices, with flush,
// occupancy count and sticky out-of-range select detection.
module mux_pipe_n
  import mux_pipe_n_pkg::*;
#(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 1,
  localparam int unsigned SEL_W = sel_width(N_IN),
  localparam int unsigned CntW  = clog2(STAGES + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [SEL_W-1:0]      select_i,
  input  logic [N_IN*WIDTH-1:0] data_i,
  input  logic                  flush_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [WIDTH-1:0]      data_o,
  output logic [CntW-1:0]       count_o,
  output logic                  sel_err_o,
  input  logic                  clr_err_i
);

  logic [STAGES:0]   rdy;
  logic [STAGES-1:0] v;
  logic [WIDTH-1:0]  d [STAGES];
  logic [WIDTH-1:0]  sel_data;
  logic              sel_bad;
  logic              accept;
  logic              sel_err_q, sel_err_d;

  // Out-of-range selects fall back to input 0.
  always_comb begin
    sel_data = data_i[WIDTH-1:0];
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (select_i == SEL_W'(k)) begin
        sel_data = data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  assign rdy[STAGES] = ready_i;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             in_valid;
    logic [WIDTH-1:0] in_data;

    if (k == 0) begin : g_head
      assign in_valid = valid_i;
      assign in_data  = sel_data;
    end else begin : g_body
      assign in_valid = v[k-1];
      assign in_data  = d[k-1];
    end

    mux_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .flush_i   (flush_i),
      .valid_i   (in_valid),
      .data_i    (in_data),
      .rdy_next_i(rdy[k+1]),
      .rdy_o     (rdy[k]),
      .valid_o   (v[k]),
      .data_o    (d[k])
    );
  end

  assign ready_o = rdy[0];
  assign valid_o = v[STAGES-1];
  assign data_o  = d[STAGES-1];

  always_comb begin
    count_o = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      count_o = count_o + CntW'(v[k]);
    end
  end

  // A power-of-two input count leaves no unused select codes.
  if (N_IN == (32'd1 << SEL_W)) begin : g_no_err
    assign sel_bad = 1'b0;
  end else begin : g_err
    assign sel_bad = (32'(select_i) >= N_IN);
  end

  assign accept = valid_i & ready_o & ~flush_i;

  always_comb begin
    sel_err_d = sel_err_q;
    if (accept && sel_bad) begin
      sel_err_d = 1'b1;
    end else if (clr_err_i) begin
      sel_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err_o = sel_err_q;

endmodule
